dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Write-back, write-allocate data cache between the pipeline's memory stage and the memory arbiter. Two-way set-associative, 8 sets, 2-word blocks, LRU replacement. On `halt` it flushes all dirty blocks to memory and optionally stores a hit count, then raises `flushed`. Frames use the team's standard dcache frame layout: 26-bit tag, valid, dirty, two 32-bit data words.

## Interface
Parameters:
- `HITCNT_ADDR`, 32'h0000_3100, word address for the hit-count store at end of flush.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `dmemREN`  in  1  pipeline read request.
- `dmemWEN`  in  1  pipeline write request; wins if both requests are high.
- `dmemaddr`  in  32  byte address: tag [31:6], index [5:3], word [2], [1:0] ignored.
- `dmemstore`  in  32  write data.
- `halt`  in  1  flush request, level, held by the pipeline.
- `dmemload`  out  32  read data, valid while `dhit`=1.
- `dhit`  out  1  request serviced this cycle; combinational.
- `flushed`  out  1  flush complete; sticky until reset.
- `dREN`  out  1  memory read request.
- `dWEN`  out  1  memory write request.
- `daddr`  out  32  memory word address, [1:0]=0.
- `dstore`  out  32  memory write data.
- `dload`  in  32  memory read data, valid when `dwait`=0.
- `dwait`  in  1  memory busy; a transfer completes on a cycle with `dwait`=0.

## Operation
- States: IDLE, WB1, WB2, LD1, LD2, FLUSH1, FLUSH2, HLT_CNT, HALT.
- IDLE hit: tag match and valid in either way of `index`.
  - `dhit`=1 in the same cycle.
  - Read: `dmemload` = selected word.
  - Write: word updated and dirty set at the edge.
  - `lru[index]` <= not the hit way. Hit counter +1.
- IDLE miss: victim way = `lru[index]`.
  - Victim valid and dirty: go to WB1.
  - Otherwise: go to LD1.
- WB1/WB2: `dWEN`=1, `daddr` = {victim tag, index, 3'b000} then +4, `dstore` = data1 then data2. Each state advances when `dwait`=0. WB2 goes to LD1.
- LD1/LD2: `dREN`=1, `daddr` = {req tag, index, 3'b000} then +4. Capture `dload` into data1 then data2 when `dwait`=0.
  - On LD2 completion: write tag, valid=1, dirty=0; return to IDLE.
  - The retried access then hits and counts as a hit.
- `dhit`=0 in every non-IDLE state. The pipeline holds its request stable until `dhit`.
- Halt: `halt`=1 in IDLE has priority over requests. A 4-bit frame counter walks {way, set} from 0 to 15.
  - Dirty frame: FLUSH1/FLUSH2 write its two words, same addressing as WB, then clear dirty and advance.
  - Clean or invalid frame: advance in one cycle.
  - After frame 15: go to HLT_CNT (if compiled in), otherwise HALT.
- HLT_CNT: `dWEN`=1, `daddr`=`HITCNT_ADDR`, `dstore`=hit counter. Goes to HALT when `dwait`=0.
- HALT: `flushed`=1. No requests serviced and no `dhit`. Stays until reset.
- Hit counter: 32-bit, wraps modulo 2^32.

## Timing
- Reset values: state IDLE; all valid, dirty and lru = 0; counters 0; `dREN`, `dWEN`, `dhit`, `flushed` = 0; `daddr`, `dstore`, `dmemload` = 0.
- Reset asserted mid-transfer (any state): memory strobes drop asynchronously; cache contents invalidated.
- Hit latency: 0 cycles.
- Clean miss: 2 transfers + 1 IDLE cycle.
- Dirty miss: 4 transfers + 1 IDLE cycle.
- Each transfer takes at least 1 cycle, plus 1 cycle per `dwait`=1 cycle.
- Memory outputs are decoded from state only. They are held stable while `dwait`=1.
- `halt` rising while a miss is in progress: the miss completes and returns to IDLE, then the flush starts.

## Configuration
- `DCACHE_HITCNT_EN` defined: HLT_CNT state, hit counter and the `HITCNT_ADDR` store are present.
- `DCACHE_HITCNT_EN` not defined: counter logic removed and the flush goes directly to HALT. Memory traffic at halt is only dirty blocks.

## Test plan
- Reset with `RST`=1, then release -> all outputs 0, state IDLE; a read to 0x40 misses (`dhit`=0, `dREN`=1, `daddr`=0x40).
- Clean read miss at 0x44, memory returns 0xA/0xB at 0x40/0x44 with `dwait`=0 -> reads at 0x40 then 0x44; then `dhit`=1 with `dmemload`=0xB.
- Write hit 0xDEAD to 0x40, then misses to 0x80 and 0xC0 (same set, index 0) -> second miss evicts dirty LRU block 0x40: WB writes 0xDEAD@0x40 and 0xB@0x44, then loads 0xC0/0xC4.
- LRU check: read A=0x100, B=0x140, A again, then C=0x180 (all index 0) -> C replaces B; a subsequent read of A hits.
- Halt with 2 dirty frames and 5 prior hits -> exactly 4 data writes, then write of 5 to 0x3100 (macro on); then `flushed`=1 held.
- `RST` pulse during LD2 with `dwait`=1 -> `dREN` low immediately; the next access to the same address misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: two-way set-associative, write-back, write-allocate data cache.
// 8 sets x 2 ways, 2-word blocks, one LRU bit per set. On halt every dirty
// frame is written back, then the controller parks in HALT with flushed=1.
// Optional feature: define DCACHE_HITCNT_EN to keep a 32-bit hit counter and
// store it to HITCNT_ADDR as the last write of the flush.
//
// Handshakes: the pipeline raises dmemREN/dmemWEN and holds address/data
// stable until dhit=1 (the request is consumed at that clock edge); the cache
// raises dREN/dWEN with daddr/dstore and holds them stable until a cycle with
// dwait=0, which completes that transfer at the clock edge.
module dcache_ctrl #(
  parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic [3:0]  dbg_state_o
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] WB1    = 4'd1;
  localparam logic [3:0] WB2    = 4'd2;
  localparam logic [3:0] LD1    = 4'd3;
  localparam logic [3:0] LD2    = 4'd4;
  localparam logic [3:0] FLUSH1 = 4'd5;
  localparam logic [3:0] FLUSH2 = 4'd6;
  localparam logic [3:0] HALT   = 4'd8;
`ifdef DCACHE_HITCNT_EN
  localparam logic [3:0] HLT_CNT   = 4'd7;
  localparam logic [3:0] FLUSH_END = HLT_CNT;
`else
  localparam logic [3:0] FLUSH_END = HALT;
`endif

  // Frame storage, indexed by {way, set}
  logic [25:0] tag_q   [16];
  logic [31:0] data0_q [16];
  logic [31:0] data1_q [16];
  logic [15:0] valid_q, dirty_q;
  logic [7:0]  lru_q;  // per set: the way to replace next

  logic [3:0] state_q, state_d;
  logic [3:0] frame_q, frame_d;  // flush walk position {way, set}
  logic       victim_q, victim_d;

  logic [25:0] req_tag;
  logic [2:0]  req_idx;
  logic        req_word, req_any;
  logic [3:0]  f0, f1, hit_f, lru_f, vict_f;
  logic        hit0, hit1, hit_any;
  logic        unused_ok;

  assign req_tag  = dmemaddr[31:6];
  assign req_idx  = dmemaddr[5:3];
  assign req_word = dmemaddr[2];
  assign req_any  = dmemREN | dmemWEN;

  assign f0      = {1'b0, req_idx};
  assign f1      = {1'b1, req_idx};
  assign hit0    = valid_q[f0] && (tag_q[f0] == req_tag);
  assign hit1    = valid_q[f1] && (tag_q[f1] == req_tag);
  assign hit_any = hit0 | hit1;
  assign hit_f   = {~hit0, req_idx};
  assign lru_f   = {lru_q[req_idx], req_idx};
  assign vict_f  = {victim_q, req_idx};

  assign dhit        = (state_q == IDLE) && !halt && req_any && hit_any;
  assign dmemload    = dhit ? (req_word ? data1_q[hit_f] : data0_q[hit_f]) : 32'h0;
  assign flushed     = (state_q == HALT);
  assign dbg_state_o = state_q;

`ifdef DCACHE_HITCNT_EN
  logic [31:0] hitcnt_q;

  // Count every serviced request; wraps naturally at 2^32
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       hitcnt_q <= '0;
    else if (dhit) hitcnt_q <= hitcnt_q + 32'd1;
  end

  assign unused_ok = ^dmemaddr[1:0];
`else
  assign unused_ok = ^{dmemaddr[1:0], HITCNT_ADDR};
`endif

  // Next-state logic: misses, write-back/fill sequencing and the flush walk
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    victim_d = victim_q;
    case (state_q)
      IDLE: begin
        if (halt) begin
          if (valid_q[frame_q] && dirty_q[frame_q]) state_d = FLUSH1;
          else if (frame_q == 4'hF)                 state_d = FLUSH_END;
          else                                      frame_d = frame_q + 4'd1;
        end else if (req_any && !hit_any) begin
          victim_d = lru_q[req_idx];
          state_d  = (valid_q[lru_f] && dirty_q[lru_f]) ? WB1 : LD1;
        end
      end
      WB1:    if (!dwait) state_d = WB2;
      WB2:    if (!dwait) state_d = LD1;
      LD1:    if (!dwait) state_d = LD2;
      LD2:    if (!dwait) state_d = IDLE;
      FLUSH1: if (!dwait) state_d = FLUSH2;
      FLUSH2: begin
        if (!dwait) begin
          if (frame_q == 4'hF) begin
            state_d = FLUSH_END;
          end else begin
            frame_d = frame_q + 4'd1;
            state_d = IDLE;
          end
        end
      end
`ifdef DCACHE_HITCNT_EN
      HLT_CNT: if (!dwait) state_d = HALT;
`endif
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs depend only on registered state, so they stay put while dwait=1
  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = 32'h0;
    dstore = 32'h0;
    case (state_q)
      WB1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[vict_f], req_idx, 3'b000};
        dstore = data0_q[vict_f];
      end
      WB2: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[vict_f], req_idx, 3'b100};
        dstore = data1_q[vict_f];
      end
      LD1: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 3'b000};
      end
      LD2: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 3'b100};
      end
      FLUSH1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[frame_q], frame_q[2:0], 3'b000};
        dstore = data0_q[frame_q];
      end
      FLUSH2: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[frame_q], frame_q[2:0], 3'b100};
        dstore = data1_q[frame_q];
      end
`ifdef DCACHE_HITCNT_EN
      HLT_CNT: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hitcnt_q;
      end
`endif
      default: ;
    endcase
  end

  // Control state: reset invalidates the whole cache and aborts any transfer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      victim_q <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      victim_q <= victim_d;
      if (dhit) begin
        lru_q[req_idx] <= hit0;  // point at the way that was not used
        if (dmemWEN) dirty_q[hit_f] <= 1'b1;
      end
      if (state_q == LD2 && !dwait) begin
        valid_q[vict_f] <= 1'b1;
        dirty_q[vict_f] <= 1'b0;
      end
      if (state_q == FLUSH2 && !dwait) dirty_q[frame_q] <= 1'b0;
    end
  end

  // Tag and data arrays: contents are meaningless until valid, so no reset
  always_ff @(posedge CLK) begin
    if (dhit && dmemWEN) begin
      if (req_word) data1_q[hit_f] <= dmemstore;
      else          data0_q[hit_f] <= dmemstore;
    end
    if (state_q == LD1 && !dwait) data0_q[vict_f] <= dload;
    if (state_q == LD2 && !dwait) begin
      data1_q[vict_f] <= dload;
      tag_q[vict_f]   <= req_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and randomized checks of dcache_ctrl against a
// recency-ordered line model and a flat word memory.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  localparam logic [31:0] HC_ADDR = 32'h0000_3100;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_ren, dmem_wen, halt_r;
  logic [31:0] dmem_addr, dmem_store, dmem_load;
  logic        dhit, flushed, dren, dwen, dwait;
  logic [31:0] daddr, dstore, dload;
  logic [3:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.HITCNT_ADDR(HC_ADDR)) dut (
    .CLK(clk), .RST(rst),
    .dmemREN(dmem_ren), .dmemWEN(dmem_wen), .dmemaddr(dmem_addr),
    .dmemstore(dmem_store), .halt(halt_r),
    .dmemload(dmem_load), .dhit(dhit), .flushed(flushed),
    .dREN(dren), .dWEN(dwen), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait), .dbg_state_o(dbg_state)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0]  set;
    logic [25:0] tag;
    logic        dirty;
    logic [31:0] d0;
    logic [31:0] d1;
  } line_t;

  line_t       lines_q[$];          // most recently used first
  logic [64:0] exp_q[$];            // {is_write, addr, data} expected transfers
  logic [31:0] dut_mem [logic [31:0]];
  logic [31:0] mdl_mem [logic [31:0]];
  int          hit_total;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1111};
  endfunction

  function automatic logic [31:0] dut_rd(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // True LRU per set; every access finishes as a hit on its line
  task automatic model_access(input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata);
    logic [2:0]  s;
    logic [25:0] t;
    logic [31:0] base;
    int          pos, cnt, last;
    line_t       ln;
    s = addr[5:3];
    t = addr[31:6];
    pos = -1; cnt = 0; last = -1;
    for (int i = 0; i < lines_q.size(); i++) begin
      if (lines_q[i].set == s) begin
        cnt++;
        last = i;
        if (lines_q[i].tag == t) pos = i;
      end
    end
    if (pos < 0) begin
      if (cnt == 2) begin
        ln = lines_q[last];
        lines_q.delete(last);
        if (ln.dirty) begin
          base = {ln.tag, s, 3'b000};
          exp_q.push_back({1'b1, base, ln.d0});
          exp_q.push_back({1'b1, base + 32'd4, ln.d1});
          mdl_mem[base]         = ln.d0;
          mdl_mem[base + 32'd4] = ln.d1;
        end
      end
      base     = {t, s, 3'b000};
      ln.set   = s;
      ln.tag   = t;
      ln.dirty = 1'b0;
      ln.d0    = mdl_rd(base);
      ln.d1    = mdl_rd(base + 32'd4);
      exp_q.push_back({1'b0, base, 32'h0});
      exp_q.push_back({1'b0, base + 32'd4, 32'h0});
      lines_q.push_front(ln);
    end else begin
      ln = lines_q[pos];
      lines_q.delete(pos);
      lines_q.push_front(ln);
    end
    ln = lines_q[0];
    rdata = addr[2] ? ln.d1 : ln.d0;
    if (wr) begin
      if (addr[2]) ln.d1 = wdata;
      else         ln.d0 = wdata;
      ln.dirty   = 1'b1;
      lines_q[0] = ln;
    end
    hit_total++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic access(input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int n_xfer);
    logic [31:0] exp_rd;
    logic [64:0] e;
    int          n_exp;
    bit          done;
    model_access(wr, addr, wdata, exp_rd);
    n_exp  = exp_q.size();
    n_xfer = 0;
    done   = 1'b0;
    @(negedge clk);
    dmem_ren = !wr; dmem_wen = wr; dmem_addr = addr; dmem_store = wdata;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      dwait = ($urandom_range(0, 2) == 0);
      dload = dren ? dut_rd(daddr) : 32'h0;
      #1;
      if (dhit) begin
        if (!wr) chk("rd_data", dmem_load, exp_rd);
        chk("xfer_left", exp_q.size(), 0);
        done = 1'b1;
      end else if ((dren || dwen) && !dwait) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("xfer_count", n_xfer, n_exp);
        end else begin
          e = exp_q.pop_front();
          chk("xfer", {dwen, daddr, dwen ? dstore : 32'h0}, e);
        end
        if (dwen) dut_mem[daddr] = dstore;
      end
    end
    if (!done) chk("access_timeout", done, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    dmem_ren = 1'b0; dmem_wen = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; dmem_ren = 1'b0; dmem_wen = 1'b0; halt_r = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lines_q.delete();
    exp_q.delete();
    hit_total = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] fl_exp [logic [31:0]];
  logic [31:0] a;
  int          n, n_fl, n_fl_exp, n_bad, n_rd, hc_seen;

  initial begin
    rst = 1'b1; dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_addr = '0; dmem_store = '0;
    halt_r = 1'b0; dwait = 1'b0; dload = '0; hit_total = 0;
    dut_mem[32'h40] = 32'hA; dut_mem[32'h44] = 32'hB;
    mdl_mem[32'h40] = 32'hA; mdl_mem[32'h44] = 32'hB;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_dmemload", dmem_load, 0);
    chk("rst_dhit", dhit, 0);
    chk("rst_flushed", flushed, 0);
    chk("rst_dren", dren, 0);
    chk("rst_dwen", dwen, 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_dstore", dstore, 0);
    chk("rst_state", dbg_state, 0);

    // first read misses and starts a fill at the block base
    @(negedge clk);
    dmem_ren = 1'b1; dmem_addr = 32'h44; dwait = 1'b1;
    #1;
    chk("miss_dhit", dhit, 0);
    @(negedge clk);
    #1;
    chk("miss_dren", dren, 1);
    chk("miss_daddr", daddr, 32'h40);
    access(1'b0, 32'h44, 32'h0, n);
    chk("clean_miss_xfers", n, 2);

    // write hit then two conflicting misses; the second evicts the dirty block
    access(1'b1, 32'h40, 32'hDEAD, n);
    chk("write_hit_xfers", n, 0);
    access(1'b0, 32'h80, 32'h0, n);
    chk("miss_80_xfers", n, 2);
    access(1'b0, 32'hC0, 32'h0, n);
    chk("dirty_miss_xfers", n, 4);

    // LRU: A, B, A, C replaces B, A still hits
    access(1'b0, 32'h100, 32'h0, n);
    access(1'b0, 32'h140, 32'h0, n);
    access(1'b0, 32'h100, 32'h0, n);
    chk("lru_a_rehit", n, 0);
    access(1'b0, 32'h180, 32'h0, n);
    access(1'b0, 32'h100, 32'h0, n);
    chk("lru_a_kept", n, 0);

    // randomized traffic over 8 tags x 8 sets
    for (int k = 0; k < 150; k++) begin
      a = {23'h0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, $urandom, n);
    end

    // reset during LD2 with dwait=1 aborts the fill
    pulse_reset();
    @(negedge clk);
    dmem_ren = 1'b1; dmem_addr = 32'h1C0; dwait = 1'b0; dload = 32'h1234;
    @(negedge clk);
    dwait = 1'b0; dload = 32'h1234;
    @(negedge clk);
    dwait = 1'b1;
    #1;
    chk("ld2_dren", dren, 1);
    chk("ld2_daddr", daddr, 32'h1C4);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_dren", dren, 0);
    chk("rst_async_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0; dmem_ren = 1'b0;
    access(1'b0, 32'h1C0, 32'h0, n);
    chk("post_rst_miss", n, 2);

    // halt with two dirty frames and five hits
    pulse_reset();
    access(1'b1, 32'h40, 32'h1111_2222, n);
    access(1'b1, 32'h88, 32'h3333_4444, n);
    access(1'b0, 32'h40, 32'h0, n);
    access(1'b0, 32'h40, 32'h0, n);
    access(1'b0, 32'h88, 32'h0, n);
    for (int i = 0; i < lines_q.size(); i++) begin
      if (lines_q[i].dirty) begin
        fl_exp[{lines_q[i].tag, lines_q[i].set, 3'b000}] = lines_q[i].d0;
        fl_exp[{lines_q[i].tag, lines_q[i].set, 3'b100}] = lines_q[i].d1;
      end
    end
    n_fl_exp = fl_exp.size();
    n_fl = 0; n_bad = 0; n_rd = 0; hc_seen = 0;
    @(negedge clk);
    halt_r = 1'b1;
    for (int cyc = 0; cyc < 400 && !flushed; cyc++) begin
      if (cyc > 0) @(negedge clk);
      dwait = ($urandom_range(0, 2) == 0);
      #1;
      if (dren) n_rd++;
      if (dwen && !dwait) begin
`ifdef DCACHE_HITCNT_EN
        if (daddr == HC_ADDR) begin
          hc_seen++;
          chk("hitcnt_value", dstore, hit_total);
          chk("hitcnt_after_data", fl_exp.size(), 0);
        end else
`endif
        if (fl_exp.exists(daddr)) begin
          chk("flush_data", dstore, fl_exp[daddr]);
          fl_exp.delete(daddr);
          n_fl++;
        end else begin
          n_bad++;
        end
      end
    end
    chk("flushed_set", flushed, 1);
    chk("flush_writes", n_fl, 4);
    chk("flush_writes_model", n_fl, n_fl_exp);
    chk("flush_unexpected", n_bad, 0);
    chk("flush_reads", n_rd, 0);
`ifdef DCACHE_HITCNT_EN
    chk("hitcnt_writes", hc_seen, 1);
`else
    chk("hitcnt_writes", hc_seen, 0);
`endif

    // HALT is sticky and services nothing
    dmem_ren = 1'b1; dmem_addr = 32'h40;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      #1;
      chk("halt_flushed", flushed, 1);
      chk("halt_dhit", dhit, 0);
      chk("halt_strobes", {dren, dwen}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
